// File: rtl/genetico_pkg.sv
// Shared constants, FSM encoding and width helper for the
// chromosome loader and fitness evaluator.
package genetico_pkg;

    localparam int LE_BITS    = 13;
    localparam int N_LES      = 25;
    localparam int OUT_BITS   = 5;
    localparam int CHROM_BITS = N_LES * LE_BITS + 2 * OUT_BITS;
    localparam int LOAD_BYTES = (CHROM_BITS + 7) / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } estado_t;

    function automatic int fitness_w(input int n_in, input int n_out);
        return $clog2((2 ** n_in) * n_out + 1);
    endfunction

endpackage

// File: rtl/carregador_cromossomo.sv
// Byte-serial chromosome loader: assembles LSB-first bytes in a
// shadow register and commits the whole chromosome on the last byte.
module carregador_cromossomo
    import genetico_pkg::*;
#(
    parameter int CHROM_BITS = genetico_pkg::CHROM_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_data_i,
    input  logic                  enable_i,
    output logic                  load_ready_o,
    output logic [CHROM_BITS-1:0] cromossomo_o,
    output logic                  chrom_valid_o
);

    localparam int LB = (CHROM_BITS + 7) / 8;
    localparam int CW = $clog2(LB);

    logic [CW-1:0]         cnt_q;
    logic [(LB-1)*8-1:0]   shadow_q;
    logic [CHROM_BITS-1:0] crom_q;
    logic                  valid_q;
    logic [LB*8-1:0]       full;
    logic                  accept;
    logic                  last;

    assign load_ready_o  = enable_i;
    assign accept        = load_valid_i & enable_i;
    assign last          = (cnt_q == CW'(LB - 1));
    // Final byte goes straight into the commit, bypassing the shadow.
    assign full          = {load_data_i, shadow_q};
    assign cromossomo_o  = crom_q;
    assign chrom_valid_o = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            crom_q   <= '0;
            valid_q  <= 1'b0;
        end else if (accept) begin
            if (last) begin
                cnt_q   <= '0;
                crom_q  <= full[CHROM_BITS-1:0];
                valid_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                for (int k = 0; k < LB - 1; k++) begin
                    if (cnt_q == CW'(k)) begin
                        shadow_q[k*8 +: 8] <= load_data_i;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/avaliador_fitness.sv
// Fitness evaluator: sweeps every phenotype input vector, waits for
// settling, and counts output bits matching the host truth table.
module avaliador_fitness
    import genetico_pkg::*;
#(
    parameter int CHROM_BITS    = genetico_pkg::CHROM_BITS,
    parameter int N_IN          = 1,
    parameter int N_OUT         = 2,
    parameter int SETTLE_CYCLES = 4,
    localparam int N_VEC        = 2 ** N_IN,
    localparam int EXP_W        = N_VEC * N_OUT,
    localparam int FIT_W        = fitness_w(N_IN, N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    output logic                  load_ready,
    input  logic [EXP_W-1:0]      expected,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [FIT_W-1:0]      fitness,
    output logic                  chrom_valid,
    output logic [CHROM_BITS-1:0] cromossomo,
    output logic [N_IN-1:0]       chrom_in,
    input  logic [N_OUT-1:0]      chrom_out
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

    estado_t          state_q;
    logic [N_IN-1:0]  v_q;
    logic [SC_W-1:0]  sc_q;
    logic [FIT_W-1:0] acc_q;
    logic [FIT_W-1:0] fit_q;
    logic             busy_q;
    logic             done_q;
    logic [N_OUT-1:0] exp_sl;
    logic [N_OUT-1:0] match;
    logic [FIT_W-1:0] hits;
    logic             load_en;

    assign load_en  = (state_q == IDLE) & ~start;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fitness  = fit_q;
    assign chrom_in = v_q;

    carregador_cromossomo #(
        .CHROM_BITS(CHROM_BITS)
    ) u_carregador (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .enable_i     (load_en),
        .load_ready_o (load_ready),
        .cromossomo_o (cromossomo),
        .chrom_valid_o(chrom_valid)
    );

    always_comb begin
        exp_sl = '0;
        for (int v = 0; v < N_VEC; v++) begin
            if (v_q == N_IN'(v)) begin
                exp_sl = expected[v*N_OUT +: N_OUT];
            end
        end
        match = ~(chrom_out ^ exp_sl);
        hits  = '0;
        for (int b = 0; b < N_OUT; b++) begin
            hits = hits + FIT_W'(match[b]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            sc_q    <= '0;
            acc_q   <= '0;
            fit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && chrom_valid) begin
                        acc_q   <= '0;
                        v_q     <= '0;
                        sc_q    <= SC_W'(SETTLE_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sc_q == SC_W'(1)) begin
                        state_q <= SAMPLE;
                    end else begin
                        sc_q <= sc_q - 1'b1;
                    end
                end
                SAMPLE: begin
                    acc_q <= acc_q + hits;
                    if (v_q == N_IN'(N_VEC - 1)) begin
                        state_q <= FINISH;
                    end else begin
                        v_q     <= v_q + 1'b1;
                        sc_q    <= SC_W'(SETTLE_CYCLES);
                        state_q <= SETTLE;
                    end
                end
                FINISH: begin
                    fit_q   <= acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
